// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the RV32 MEM stage: one valid/ready bus
// transaction per load/store, with pipeline stall, lane steering and load extension.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_funct3,
    input  logic        im_stall,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    output logic        dm_stall,
    output logic [31:0] load_data,
    output logic        access_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam bit               LP_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LP_TO_LAST = LP_TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_req_write;
    logic [31:0]        r_req_addr;
    logic [31:0]        r_req_wdata;
    logic [3:0]         r_req_wstrb;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic [31:0]        r_load_data;
    logic               r_access_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_access;
    logic               w_illegal;
    logic [3:0]         w_store_wstrb;
    logic [31:0]        w_store_wdata;
    logic [31:0]        w_lane;
    logic [31:0]        w_load_ext;
    logic               w_timeout;

    assign w_access  = mem_read | mem_write;
    assign w_timeout = LP_TO_EN && (r_cnt == LP_TO_LAST);

    // Legality depends only on funct3 and the alignment of the byte address.
    always_comb begin
        w_illegal = 1'b0;
        case (mem_funct3)
            3'b000, 3'b100: w_illegal = 1'b0;
            3'b001, 3'b101: w_illegal = mem_addr[0];
            3'b010:         w_illegal = |mem_addr[1:0];
            default:        w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_store_wstrb = 4'b1111;
        w_store_wdata = mem_wdata;
        case (mem_funct3[1:0])
            2'b00: begin
                w_store_wstrb = 4'b0001 << mem_addr[1:0];
                w_store_wdata = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                w_store_wstrb = 4'b0011 << mem_addr[1:0];
                w_store_wdata = {2{mem_wdata[15:0]}};
            end
            default: begin
                w_store_wstrb = 4'b1111;
                w_store_wdata = mem_wdata;
            end
        endcase
    end

    always_comb begin
        w_lane     = resp_rdata >> {r_off, 3'b000};
        w_load_ext = resp_rdata;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_ext = {24'h0, w_lane[7:0]};
            3'b101:  w_load_ext = {16'h0, w_lane[15:0]};
            default: w_load_ext = resp_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next_state = w_illegal ? DONE : REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (!im_stall) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_valid = (r_state == REQ);
        dm_stall  = ((r_state == IDLE) && w_access) || (r_state == REQ) || (r_state == WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_write  <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_wstrb  <= '0;
            r_funct3     <= '0;
            r_off        <= '0;
            r_load_data  <= '0;
            r_access_err <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_illegal) begin
                            r_access_err <= 1'b1;
                            r_load_data  <= '0;
                        end else begin
                            r_req_write <= mem_write;
                            r_req_addr  <= {mem_addr[31:2], 2'b00};
                            r_req_wdata <= mem_write ? w_store_wdata : '0;
                            r_req_wstrb <= mem_write ? w_store_wstrb : '0;
                            r_funct3    <= mem_funct3;
                            r_off       <= mem_addr[1:0];
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        r_cnt <= '0;
                    end
                end
                WAIT: begin
                    // A response in the final timeout cycle still wins over the error.
                    if (resp_valid) begin
                        r_access_err <= 1'b0;
                        if (!r_req_write) begin
                            r_load_data <= w_load_ext;
                        end
                    end else if (w_timeout) begin
                        r_access_err <= 1'b1;
                        r_load_data  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_write  = r_req_write;
    assign req_addr   = r_req_addr;
    assign req_wdata  = r_req_wdata;
    assign req_wstrb  = r_req_wstrb;
    assign load_data  = r_load_data;
    assign access_err = r_access_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl against a transaction-level model.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        im_stall;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        dm_stall;
    logic [31:0] load_data;
    logic        access_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] exp_ld  = '0;
    logic        exp_err = 1'b0;

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3),
        .im_stall(im_stall),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .dm_stall(dm_stall),
        .load_data(load_data),
        .access_err(access_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] w;
        w = rdata >> (int'(off) * 8);
        case (f3)
            3'b000:  return 32'(int'(byte'(w[7:0])));
            3'b001:  return 32'(int'(shortint'(w[15:0])));
            3'b100:  return w & 32'h0000_00FF;
            3'b101:  return w & 32'h0000_FFFF;
            default: return rdata;
        endcase
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_access(input bit wr, input bit both, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int unsigned rdy_dly, input bit respond,
                              input int unsigned resp_dly, input logic [31:0] rdata,
                              input int unsigned hold);
        int unsigned sz;
        bit          illegal;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        int unsigned stalls;
        int unsigned e_stalls;
        bit          got;
        sz      = size_of(f3);
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((addr % sz) != 0);
        e_strb  = wr ? 4'(((1 << sz) - 1) << addr[1:0]) : 4'b0000;
        e_wd    = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                  (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        stalls  = 0;
        got     = 1'b0;

        mem_read   = !wr || both;
        mem_write  = wr;
        mem_funct3 = f3;
        mem_addr   = addr;
        mem_wdata  = wd;
        im_stall   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = rdata;
        #1;
        if (dm_stall) stalls++;
        check("idle_stall", dm_stall, 1'b1);
        check("idle_req_valid", req_valid, 1'b0);
        step();

        if (!illegal) begin
            for (int i = 0; i <= int'(rdy_dly); i++) begin
                req_ready = (i == int'(rdy_dly));
                #1;
                if (dm_stall) stalls++;
                check("req_valid", req_valid, 1'b1);
                check("req_addr", req_addr, {addr[31:2], 2'b00});
                check("req_write", req_write, wr);
                check("req_wstrb", req_wstrb, e_strb);
                if (wr) check("req_wdata", req_wdata, e_wd);
                step();
            end
            req_ready = 1'b0;
            for (int j = 0; j < int'(TO) && !got; j++) begin
                resp_valid = respond && (j == int'(resp_dly));
                #1;
                if (dm_stall) stalls++;
                check("wait_req_valid", req_valid, 1'b0);
                got = resp_valid;
                step();
            end
            resp_valid = 1'b0;
        end

        if (illegal || !got) begin
            exp_err = 1'b1;
            exp_ld  = '0;
        end else begin
            exp_err = 1'b0;
            if (!wr) exp_ld = model_load(f3, addr[1:0], rdata);
        end
        e_stalls = illegal ? 1 : (1 + rdy_dly + 1 + (got ? resp_dly + 1 : TO));
        check("stall_cycles", stalls, e_stalls);

        for (int k = 0; k <= int'(hold); k++) begin
            im_stall = (k < int'(hold));
            #1;
            check("done_stall", dm_stall, 1'b0);
            check("done_req_valid", req_valid, 1'b0);
            check("done_load_data", load_data, exp_ld);
            check("done_access_err", access_err, exp_err);
            step();
        end
        im_stall  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic idle_cycle(input bit spurious);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = spurious;
        resp_rdata = $urandom;
        #1;
        check("idle_nostall", dm_stall, 1'b0);
        check("idle_noreq", req_valid, 1'b0);
        check("idle_load_held", load_data, exp_ld);
        check("idle_err_held", access_err, exp_err);
        step();
        resp_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, req_valid, 1'b0);
        check({tag, "_req_write"}, req_write, 1'b0);
        check({tag, "_req_addr"}, req_addr, 32'h0);
        check({tag, "_req_wdata"}, req_wdata, 32'h0);
        check({tag, "_req_wstrb"}, req_wstrb, 4'h0);
        check({tag, "_load_data"}, load_data, 32'h0);
        check({tag, "_access_err"}, access_err, 1'b0);
        check({tag, "_dm_stall"}, dm_stall, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        im_stall   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        step();

        run_access(1'b0, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 1'b1, 0, 32'h80FF_1234, 0);
        check("tp_lb_value", load_data, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 1'b1, 1, 32'h1111_2222, 0);
        check("tp_sh_keeps_load", load_data, 32'hFFFF_FF80);
        run_access(1'b0, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5, 1'b1, 2, 32'hDEAD_BEEF, 0);
        run_access(1'b0, 1'b0, 3'b101, 32'h0000_4001, 32'h0, 0, 1'b1, 0, 32'h1234_5678, 0);
        check("tp_lhu_err", access_err, 1'b1);
        run_access(1'b0, 1'b0, 3'b010, 32'h0000_5004, 32'h0, 1, 1'b0, 0, 32'h0, 0);
        check("tp_timeout_err", access_err, 1'b1);
        idle_cycle(1'b1);
        run_access(1'b0, 1'b0, 3'b010, 32'h0000_6008, 32'h0, 0, 1'b1, 0, 32'hCAFE_F00D, 3);
        check("tp_hold_value", load_data, 32'hCAFE_F00D);
        run_access(1'b1, 1'b1, 3'b000, 32'h0000_7001, 32'h0000_005A, 0, 1'b1, 0, 32'h0, 1);

        // Reset while waiting for the response aborts the transaction.
        mem_read   = 1'b1;
        mem_funct3 = 3'b010;
        mem_addr   = 32'h0000_8000;
        step();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("wait_rst_req_valid", req_valid, 1'b0);
        mem_read = 1'b0;
        #1;
        check_reset_outputs("wait_rst");
        reset   = 1'b0;
        exp_ld  = '0;
        exp_err = 1'b0;
        step();
        idle_cycle(1'b1);

        for (int t = 0; t < 150; t++) begin
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] addr;
            wr   = ($urandom_range(0, 2) == 0);
            addr = $urandom;
            if (wr) begin
                f3 = ($urandom_range(0, 9) == 0) ? 3'd6 : 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            run_access(wr, wr && ($urandom_range(0, 3) == 0), f3, addr, $urandom,
                       $urandom_range(0, 3), ($urandom_range(0, 9) != 0),
                       $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory access controller for the MEM stage of the RV32 pipeline.
- Takes a load or store from the MEM stage and issues one bus transaction with a valid/ready request and a response phase.
- Drives dm_stall, which the pipeline registers consume to freeze, and returns aligned, sign- or zero-extended load data.
- Sits between the EXE/MEM register outputs and the data-memory bus wrapper.

Parameters:
TIMEOUT_CYCLES, 255, max WAIT cycles before bus error; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  MEM-stage load request
mem_write  input  1  MEM-stage store request
mem_addr  input  32  byte address
mem_wdata  input  32  store data in bits [7:0], [15:0] or [31:0]
mem_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
im_stall  input  1  instruction-side stall; pipeline is frozen
req_valid  output  1  bus request valid
req_ready  input  1  bus accepts request
req_write  output  1  1 = store, 0 = load
req_addr  output  32  word address {mem_addr[31:2],2'b00}
req_wdata  output  32  lane-replicated store data
req_wstrb  output  4  byte enables (0000 for loads)
resp_valid  input  1  bus response valid (load data or store ack)
resp_rdata  input  32  load word
dm_stall  output  1  freeze pipeline
load_data  output  32  extended load result, valid in DONE
access_err  output  1  misaligned/illegal access or bus timeout, valid in DONE

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset puts the block in IDLE, and reset mid-transaction also aborts to IDLE.
- Reset values: req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_wstrb=0, load_data=0, access_err=0, timeout count=0.
- access = mem_read | mem_write. If both are high, treat as a store.
- dm_stall = (IDLE & access) | REQ | WAIT. It is combinational from IDLE so the pipeline freezes in the first cycle.
- IDLE handling of an access:
  - Illegal funct3 (011, 110, 111), a misaligned half (addr[0]=1) or a misaligned word (addr[1:0]!=0) goes to DONE with access_err=1 and load_data=0. No bus request is issued.
  - Otherwise, request fields are registered from the inputs and the state goes to REQ.
- REQ: req_valid=1, and request fields are held stable. On req_valid & req_ready, go to WAIT and clear the counter.
- WAIT:
  - On resp_valid, go to DONE. For loads, load_data is the extended lane of resp_rdata; access_err=0.
  - Else, if TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1, go to DONE with access_err=1 and load_data=0.
  - Else count+1.
- The responder never asserts resp_valid in the handshake cycle. resp_valid outside WAIT is ignored, including late responses after a timeout or reset.
- DONE: dm_stall=0; load_data and access_err are held.
  - Stay in DONE while im_stall=1, so the same instruction is never reissued.
  - Go to IDLE when im_stall=0.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata as given.
- Load extraction: select the byte/half at addr[1:0].
  - B and H sign-extend.
  - BU and HU zero-extend.
  - W passes through.
- Stores complete on resp_valid exactly as loads; load_data is unchanged for stores.
- Minimum stall: 3 cycles (IDLE detect, REQ with immediate ready, WAIT with response next cycle). Result is in DONE, 4th cycle.
- A new access may be detected in the IDLE cycle directly following DONE; there is no extra bubble.

Test Plan:
- LB at addr 0x1003 with resp_rdata=0x80FF_1234 and ready and resp immediate -> req_addr=0x1000, wstrb=0000, dm_stall high 3 cycles, load_data=0xFFFF_FF80, access_err=0.
- SH at addr 0x2002 with wdata=0x0000_ABCD -> req_write=1, wstrb=1100, req_wdata=0xABCD_ABCD, completes on ack, load_data unchanged.
- LW at 0x3000 with req_ready held low 5 cycles -> req_valid and request fields held stable for 5 cycles, dm_stall high throughout, then handshake, then WAIT.
- LHU at 0x4001 (misaligned) -> no req_valid, dm_stall high 1 cycle, DONE with access_err=1, load_data=0.
- TIMEOUT_CYCLES=4 with no response -> DONE after 4 WAIT cycles with access_err=1; a later resp_valid in IDLE is ignored.
- LW completes while im_stall=1 for 3 cycles -> stays in DONE with load_data held and no second req_valid. Asserting reset during WAIT -> IDLE, req_valid=0, dm_stall=0 when access is low.
